peaks_readout_port: RTL and testbench

//  Software-facing read port for peak-finder results. Captures each {time counter, PEAKS x (amplitude, freq)}

---
 rtl/peaks_rd_pkg.sv | 48 ++++
 rtl/peak_frame_byte_mux.sv | 32 +++
 rtl/peaks_readout_port.sv | 129 ++++++++++++
 tb/tb_peaks_readout_port.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/peaks_rd_pkg.sv
// Shared parameters, register map and frame layout for the peak-finder readout port.
package peaks_rd_pkg;

  localparam int PEAKS  = 6;
  localparam int AMPL_W = 32;
  localparam int FREQ_W = 16;
  localparam int TIME_W = 16;

  function automatic int bytes_of(input int width);
    return (width + 7) / 8;
  endfunction

  localparam int AB          = bytes_of(AMPL_W);
  localparam int FB          = bytes_of(FREQ_W);
  localparam int TB          = bytes_of(TIME_W);
  localparam int FRAME_BYTES = TB + PEAKS * (AB + FB);
  localparam int PTR_W       = $clog2(FRAME_BYTES);

  // Byte offsets of peak i's fields inside the serialised frame
  function automatic int amp_offset(input int i);
    return TB + i * (AB + FB);
  endfunction

  function automatic int freq_offset(input int i);
    return TB + i * (AB + FB) + AB;
  endfunction

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_LENGTH  = 3'd2;
  localparam logic [2:0] ADDR_RDPTR   = 3'd3;
  localparam logic [2:0] ADDR_DATA    = 3'd4;

  localparam int ST_FRONT_VALID = 0;
  localparam int ST_BACK_FULL   = 1;
  localparam int ST_OVERRUN     = 2;

  localparam int CTL_RELEASE = 0;
  localparam int CTL_CLR_OVR = 1;
  localparam int CTL_IRQ_EN  = 2;

  typedef struct packed {
    logic [TIME_W-1:0]             counter;
    logic [PEAKS-1:0][AMPL_W-1:0]  amp;
    logic [PEAKS-1:0][FREQ_W-1:0]  freq;
  } frame_t;

endpackage

// File: rtl/peak_frame_byte_mux.sv
// Combinational selector: serialises a frame (counter, then amp/freq per peak, little-endian,
// zero-padded) and returns byte[idx]; out-of-range indices return 0.
module peak_frame_byte_mux
  import peaks_rd_pkg::*;
(
  input  frame_t            frame,
  input  logic [PTR_W-1:0]  idx,
  output logic [7:0]        byte_out
);

  localparam int TW8 = TB * 8;
  localparam int AW8 = AB * 8;
  localparam int FW8 = FB * 8;

  logic [FRAME_BYTES*8-1:0] flat;
  logic [PTR_W+2:0]         bit_idx;

  assign flat[TW8-1:0] = TW8'(frame.counter);

  for (genvar i = 0; i < PEAKS; i++) begin : g_peak
    assign flat[amp_offset(i)*8 +: AW8]  = AW8'(frame.amp[i]);
    assign flat[freq_offset(i)*8 +: FW8] = FW8'(frame.freq[i]);
  end

  assign bit_idx = {idx, 3'b000};

  always_comb begin
    byte_out = 8'h00;
    if (idx < PTR_W'(FRAME_BYTES)) byte_out = flat[bit_idx +: 8];
  end

endmodule

// File: rtl/peaks_readout_port.sv
// Double-buffered software read port for peak-finder frames, served bytewise over an 8-bit bus.
// Optional level interrupt on front_valid when PEAKS_RD_IRQ_EN is defined.
module peaks_readout_port
  import peaks_rd_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [PEAKS-1:0][AMPL_W-1:0] amplitudes_in,
  input  logic [PEAKS-1:0][FREQ_W-1:0] freqs_in,
  input  logic [TIME_W-1:0]            counter_in,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic                         write,
  input  logic [2:0]                   address,
  input  logic [7:0]                   writedata,
  output logic [7:0]                   readdata
`ifdef PEAKS_RD_IRQ_EN
  ,
  output logic                         irq
`endif
);

  frame_t           in_frame;
  frame_t           back_buf;
  frame_t           front_buf;
  logic             back_full;
  logic             front_valid;
  logic             overrun;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       front_byte;

  logic bus_wr;
  logic bus_rd;
  logic swap;
  logic release_front;
  logic clear_ovr;
  logic ptr_wr;
  logic data_rd;

  always_comb begin
    in_frame         = '0;
    in_frame.counter = counter_in;
    in_frame.amp     = amplitudes_in;
    in_frame.freq    = freqs_in;
  end

  // A simultaneous read and write is treated purely as a write
  assign bus_wr        = chipselect & write;
  assign bus_rd        = chipselect & read & ~write;
  assign swap          = ~front_valid & back_full;
  assign release_front = bus_wr && (address == ADDR_CONTROL) && writedata[CTL_RELEASE];
  assign clear_ovr     = bus_wr && (address == ADDR_CONTROL) && writedata[CTL_CLR_OVR];
  assign ptr_wr        = bus_wr && (address == ADDR_RDPTR) && (writedata < 8'(FRAME_BYTES));
  assign data_rd       = bus_rd && (address == ADDR_DATA) && front_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back_buf  <= '0;
      back_full <= 1'b0;
    end else if (valid_in) begin
      back_buf  <= in_frame;
      back_full <= 1'b1;
    end else if (swap) begin
      back_full <= 1'b0;
    end
  end

  // A capture into an already-full back buffer loses a frame, unless the swap drains it this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             overrun <= 1'b0;
    else if (valid_in && back_full && !swap) overrun <= 1'b1;
    else if (clear_ovr)                    overrun <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_buf   <= '0;
      front_valid <= 1'b0;
    end else if (swap) begin
      front_buf   <= back_buf;
      front_valid <= 1'b1;
    end else if (release_front) begin
      front_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_ptr <= '0;
    else if (swap)    rd_ptr <= '0;
    else if (ptr_wr)  rd_ptr <= writedata[PTR_W-1:0];
    else if (data_rd) rd_ptr <= (rd_ptr == PTR_W'(FRAME_BYTES - 1)) ? '0 : rd_ptr + 1'b1;
  end

  peak_frame_byte_mux u_byte_mux (
    .frame    (front_buf),
    .idx      (rd_ptr),
    .byte_out (front_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 8'h00;
    end else if (bus_rd) begin
      case (address)
        ADDR_STATUS: readdata <= {5'b0, overrun, back_full, front_valid};
        ADDR_LENGTH: readdata <= 8'(FRAME_BYTES);
        ADDR_RDPTR:  readdata <= 8'(rd_ptr);
        ADDR_DATA:   readdata <= front_valid ? front_byte : 8'h00;
        default:     readdata <= 8'h00;
      endcase
    end
  end

`ifdef PEAKS_RD_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_en <= 1'b0;
    else if (bus_wr && (address == ADDR_CONTROL)) irq_en <= writedata[CTL_IRQ_EN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_en & front_valid;
  end
`endif

endmodule

// File: tb/tb_peaks_readout_port.sv
// Scoreboard bench for peaks_readout_port: expected bytes queued at each bus read, checked on readdata.
module tb_peaks_readout_port;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [5:0][31:0]  amplitudes_in;
  logic [5:0][15:0]  freqs_in;
  logic [15:0]       counter_in;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [2:0]        address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
`ifdef PEAKS_RD_IRQ_EN
  logic              irq;
`endif

  peaks_readout_port dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .amplitudes_in (amplitudes_in),
    .freqs_in      (freqs_in),
    .counter_in    (counter_in),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata)
`ifdef PEAKS_RD_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic [15:0] f_ctr [5];
  logic [31:0] f_amp [5][6];
  logic [15:0] f_frq [5][6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Serialised frame: 2 counter bytes, then per peak 4 amplitude bytes and 2 frequency bytes, LSB first
  function automatic logic [7:0] exp_byte(input int id, input int k);
    int j, p, r;
    if (k < 2) return 8'(f_ctr[id] >> (8 * k));
    j = k - 2;
    p = j / 6;
    r = j % 6;
    if (r < 4) return 8'(f_amp[id][p] >> (8 * r));
    return 8'(f_frq[id][p] >> (8 * (r - 4)));
  endfunction

  // All bus/stream tasks start and end on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk(tag_q.pop_front(), 32'(readdata), 32'(exp_q.pop_front()));
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic drive_frame(input int id);
    counter_in = f_ctr[id];
    for (int p = 0; p < 6; p++) begin
      amplitudes_in[p] = f_amp[id][p];
      freqs_in[p]      = f_frq[id][p];
    end
  endtask

  task automatic pulse(input int id);
    drive_frame(id);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  initial begin
    for (int f = 0; f < 5; f++) begin
      f_ctr[f] = 16'($urandom);
      for (int p = 0; p < 6; p++) begin
        f_amp[f][p] = $urandom;
        f_frq[f][p] = 16'($urandom);
      end
    end
    f_ctr[0]    = 16'h1234;
    f_amp[0][0] = 32'hA1B2C3D4;
    f_frq[0][0] = 16'h0057;

    reset = 1'b1; valid_in = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 3'd0; writedata = 8'h00; counter_in = '0; amplitudes_in = '0; freqs_in = '0;
    idle(2);
    chk("rst_readdata", 32'(readdata), 32'h00);
`ifdef PEAKS_RD_IRQ_EN
    chk("rst_irq", 32'(irq), 32'h0);
`endif
    reset = 1'b0;
    idle(1);
    bus_rd(3'd0, 8'h00, "st_empty");
    bus_rd(3'd3, 8'h00, "rdptr_rst");

    // First frame: capture, promote, read it out completely
    pulse(0);
    idle(1);
    bus_rd(3'd0, 8'h01, "st_front");
    bus_rd(3'd2, 8'd38, "length");
    chk("known_b2", 32'(exp_byte(0, 2)), 32'hD4);
    for (int k = 0; k < 38; k++) bus_rd(3'd4, exp_byte(0, k), $sformatf("data0_%0d", k));
    bus_rd(3'd4, 8'h34, "data_wrap");
    bus_rd(3'd3, 8'h01, "rdptr_wrap");

    bus_wr(3'd3, 8'd5);
    bus_rd(3'd4, exp_byte(0, 5), "data_at5");
    bus_wr(3'd3, 8'd38);
    bus_rd(3'd3, 8'd6, "rdptr_ignore");
    bus_wr(3'd3, 8'd37);
    bus_rd(3'd4, exp_byte(0, 37), "data_last");
    bus_rd(3'd3, 8'd0, "rdptr_last_wrap");

    // Back buffer fill and overrun
    pulse(1);
    bus_rd(3'd0, 8'h03, "st_back");
    pulse(2);
    bus_rd(3'd0, 8'h07, "st_ovr");
    bus_wr(3'd1, 8'h02);
    bus_rd(3'd0, 8'h03, "st_ovr_clr");
    drive_frame(2);
    valid_in = 1'b1;
    bus_wr(3'd1, 8'h02);
    valid_in = 1'b0;
    bus_rd(3'd0, 8'h07, "ovr_set_wins");
    bus_wr(3'd1, 8'h02);

    // Release with a back frame pending -> swap on the following cycle
    bus_wr(3'd1, 8'h01);
    idle(1);
    bus_rd(3'd0, 8'h01, "st_swapped");
    bus_rd(3'd3, 8'h00, "rdptr_swap");
    for (int k = 0; k < 3; k++) bus_rd(3'd4, exp_byte(2, k), $sformatf("data2_%0d", k));

    // Release with nothing behind it
    bus_wr(3'd1, 8'h01);
    idle(1);
    bus_rd(3'd0, 8'h00, "st_released");
    bus_rd(3'd2, 8'd38, "length2");
    bus_rd(3'd4, 8'h00, "data_invalid");
    bus_rd(3'd3, 8'd3, "rdptr_held");
    bus_rd(3'd2, 8'd38, "length3");
    bus_rd(3'd6, 8'h00, "addr6");
    bus_rd(3'd2, 8'd38, "length4");
    bus_rd(3'd1, 8'h00, "ctl_read");
    bus_rd(3'd2, 8'd38, "length5");
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 3'd3; writedata = 8'd2;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    chk("rw_hold", 32'(readdata), 32'd38);
    bus_rd(3'd3, 8'd2, "rw_is_write");

    // Back-to-back frames: second capture coincides with the swap
    pulse(3);
    pulse(4);
    idle(1);
    bus_rd(3'd0, 8'h03, "st_swap_cap");
    bus_rd(3'd4, exp_byte(3, 0), "data3_0");
    bus_rd(3'd4, exp_byte(3, 1), "data3_1");
    bus_wr(3'd1, 8'h01);
    idle(1);
    bus_rd(3'd0, 8'h01, "st_after_rel");
    bus_rd(3'd4, exp_byte(4, 0), "data4_0");

`ifdef PEAKS_RD_IRQ_EN
    begin
      int waited;
      bus_wr(3'd1, 8'h01);
      idle(1);
      bus_wr(3'd1, 8'h04);
      idle(1);
      chk("irq_idle", 32'(irq), 32'h0);
      pulse(0);
      waited = 0;
      while (irq !== 1'b1 && waited < 3) begin
        idle(1);
        waited++;
      end
      chk("irq_set", 32'(irq), 32'h1);
      bus_wr(3'd1, 8'h05);
      idle(1);
      chk("irq_clr", 32'(irq), 32'h0);
      bus_wr(3'd1, 8'h04);
      pulse(1);
      idle(2);
      chk("irq_again", 32'(irq), 32'h1);
    end
`endif

    // Asynchronous reset in the middle of a DATA read
    bus_rd(3'd2, 8'd38, "length_pre_rst");
    chipselect = 1'b1; read = 1'b1; address = 3'd4;
    #2 reset = 1'b1;
    #1 chk("rst_mid_readdata", 32'(readdata), 32'h00);
`ifdef PEAKS_RD_IRQ_EN
    chk("rst_mid_irq", 32'(irq), 32'h0);
`endif
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    reset = 1'b0;
    idle(1);
    bus_rd(3'd0, 8'h00, "st_post_rst");
    bus_rd(3'd3, 8'h00, "rdptr_post_rst");
    bus_rd(3'd4, 8'h00, "data_post_rst");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
